// File: rtl/wb_demux1to3_32.sv
// Registered 1-to-3 write-data distributor: one upstream valid/ready word is
// steered to destination A, B or C by a 2-bit select, with a ready timeout.
module wb_demux1to3_32 #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [WIDTH-1:0] c_data,
  output logic             busy,
  output logic             err,
  output logic             err_cause
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [1:0] SEL_B   = 2'b00;
  localparam logic [1:0] SEL_A   = 2'b01;
  localparam logic [1:0] SEL_C   = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t             state_r, next_state_s;
  logic [1:0]         sel_r, sel_nxt_s;
  logic [WIDTH-1:0]   hold_r, hold_nxt_s;
  logic [7:0]         cnt_r, cnt_nxt_s;
  logic               in_ready_r, a_valid_r, b_valid_r, c_valid_r;
  logic               busy_r, err_r, err_cause_r;
  logic               err_nxt_s, err_cause_nxt_s;
  logic               accept_s, dst_ready_s, timeout_s;

  assign accept_s  = in_valid && in_ready_r;
  assign timeout_s = (cnt_r == CNT_LAST) && !dst_ready_s;

  // Only the captured destination's ready can complete a transfer
  always_comb begin
    dst_ready_s = 1'b0;
    case (sel_r)
      SEL_B:   dst_ready_s = b_ready;
      SEL_A:   dst_ready_s = a_ready;
      SEL_C:   dst_ready_s = c_ready;
      default: dst_ready_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (in_sel != SEL_BAD)) begin
          next_state_s = SEND;
        end else begin
          next_state_s = IDLE;
        end
      end
      SEND: begin
        if (dst_ready_s || timeout_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = SEND;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the datapath and flag registers
  always_comb begin
    sel_nxt_s       = sel_r;
    hold_nxt_s      = hold_r;
    cnt_nxt_s       = cnt_r;
    err_nxt_s       = 1'b0;
    err_cause_nxt_s = err_cause_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          sel_nxt_s  = in_sel;
          hold_nxt_s = in_data;
          cnt_nxt_s  = 8'd0;
          if (in_sel == SEL_BAD) begin
            err_nxt_s       = 1'b1;
            err_cause_nxt_s = 1'b0;
          end else begin
            err_nxt_s = 1'b0;
          end
        end else begin
          sel_nxt_s = sel_r;
        end
      end
      SEND: begin
        if (!dst_ready_s) begin
          // Counter saturates so a large TIMEOUT can never wrap past its limit
          cnt_nxt_s = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
          if (timeout_s) begin
            err_nxt_s       = 1'b1;
            err_cause_nxt_s = 1'b1;
          end else begin
            err_nxt_s = 1'b0;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        err_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers, all loaded from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r       <= 2'b00;
      hold_r      <= '0;
      cnt_r       <= 8'd0;
      in_ready_r  <= 1'b0;
      a_valid_r   <= 1'b0;
      b_valid_r   <= 1'b0;
      c_valid_r   <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      err_cause_r <= 1'b0;
    end else begin
      sel_r       <= sel_nxt_s;
      hold_r      <= hold_nxt_s;
      cnt_r       <= cnt_nxt_s;
      in_ready_r  <= (next_state_s == IDLE);
      a_valid_r   <= (next_state_s == SEND) && (sel_nxt_s == SEL_A);
      b_valid_r   <= (next_state_s == SEND) && (sel_nxt_s == SEL_B);
      c_valid_r   <= (next_state_s == SEND) && (sel_nxt_s == SEL_C);
      busy_r      <= (next_state_s == SEND);
      err_r       <= err_nxt_s;
      err_cause_r <= err_cause_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign a_valid   = a_valid_r;
  assign b_valid   = b_valid_r;
  assign c_valid   = c_valid_r;
  assign a_data    = hold_r;
  assign b_data    = hold_r;
  assign c_data    = hold_r;
  assign busy      = busy_r;
  assign err       = err_r;
  assign err_cause = err_cause_r;

endmodule

// File: tb/tb_wb_demux1to3_32.sv
// Directed self-checking bench for wb_demux1to3_32 (TIMEOUT = 16).
module tb_wb_demux1to3_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_ready, b_ready, c_ready;
  logic [31:0] a_data, b_data, c_data;
  logic        busy, err, err_cause;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int vcnt;

  wb_demux1to3_32 #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .busy(busy), .err(err), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'b00; in_data = 32'h0;
    a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_valids", {a_valid, b_valid, c_valid}, 32'd0);
    check("rst_busy_err", {busy, err, err_cause}, 32'd0);
    check("rst_hold", a_data, 32'h0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 32'd1);

    // Single transfer to A, destination ready immediately
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'hDEADBEEF; a_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("a_valid_on", {a_valid, b_valid, c_valid}, 32'd4);
    check("a_data", a_data, 32'hDEADBEEF);
    check("a_in_ready_low", in_ready, 32'd0);
    check("a_busy", busy, 32'd1);
    tick();
    check("a_done", {a_valid, b_valid, c_valid, in_ready, busy, err}, 32'b000100);
    a_ready = 1'b0;

    // Back-to-back B then C, with ignored data while in_ready is low
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'h11111111;
    tick();
    check("b_valid_on", {a_valid, b_valid, c_valid}, 32'd2);
    check("b_data", b_data, 32'h11111111);
    in_sel = 2'b10; in_data = 32'h22222222;
    tick();
    check("b_done", {b_valid, in_ready, err}, 32'b010);
    check("hold_ignored", c_data, 32'h11111111);
    tick();
    in_valid = 1'b0;
    check("c_valid_on", {a_valid, b_valid, c_valid}, 32'd1);
    check("c_data", c_data, 32'h22222222);
    tick();
    check("c_done", {c_valid, in_ready, err}, 32'b010);

    // Timeout on C
    a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'b10; in_data = 32'hCAFEF00D;
    tick();
    in_valid = 1'b0;
    vcnt = 0;
    while (c_valid && vcnt < 40) begin
      if (err) vcnt = 100;
      else begin vcnt++; tick(); end
    end
    check("to_valid_cycles", vcnt, 32'd16);
    check("to_err", {c_valid, err, err_cause, in_ready, busy}, 32'b01110);
    tick();
    check("to_err_pulse", {err, err_cause}, 32'b01);

    // Next word accepted normally after timeout
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'h0BADC0DE; b_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_to_b", {b_valid, b_data}, {1'b1, 32'h0BADC0DE});
    tick();
    check("post_to_done", {b_valid, err, in_ready}, 32'b001);
    b_ready = 1'b0;

    // Ready arriving in the 16th cycle wins over timeout
    in_valid = 1'b1; in_sel = 2'b10; in_data = 32'h0F0F0F0F;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("late_still_valid", {c_valid, err}, 32'b10);
    c_ready = 1'b1;
    tick();
    c_ready = 1'b0;
    check("late_done", {c_valid, err, in_ready}, 32'b001);
    tick();
    check("late_no_err", err, 32'd0);

    // Invalid select: dropped, err with cause 0, back-to-back
    in_valid = 1'b1; in_sel = 2'b11; in_data = 32'h12345678;
    tick();
    check("inv_err1", {a_valid, b_valid, c_valid, err, err_cause, in_ready}, 32'b000101);
    tick();
    in_valid = 1'b0;
    check("inv_err2", {a_valid, b_valid, c_valid, err, err_cause, in_ready}, 32'b000101);
    tick();
    check("inv_clear", {err, err_cause, in_ready, busy}, 32'b0010);

    // Only A targeted; B and C ready ignored
    a_ready = 1'b0; b_ready = 1'b1; c_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'hA5A5A5A5;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("a_wait", {a_valid, b_valid, c_valid, busy, in_ready}, 32'b10010);
    a_ready = 1'b1;
    tick();
    check("a_wait_done", {a_valid, in_ready, err}, 32'b010);
    b_ready = 1'b0; c_ready = 1'b0; a_ready = 1'b0;

    // Asynchronous reset mid-transfer
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'h55AA55AA;
    tick();
    in_valid = 1'b0;
    check("rst_mid_pre", a_valid, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_async", {a_valid, busy, in_ready, err}, 32'b0000);
    check("rst_mid_hold", a_data, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_release", {in_ready, a_valid, err, busy}, 32'b1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
